alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_nibble_slice.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, FSM
// state encoding and the slice width.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    // Opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Sequencer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice. cin/cout chain between nibble passes;
// c3 is the carry into bit 3, used for signed overflow on the top nibble.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    input  logic       cin,
    output logic [3:0] y,
    output logic       cout,
    output logic       c3
);

    logic [3:0] b_eff;
    logic [4:0] sum;
    logic [3:0] sum_lo;

    // Shared adder: SUB is A + ~B with the chain carry acting as carry-in
    always_comb begin
        b_eff  = (op == OP_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        sum_lo = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    end

    // Opcode decode; non-arithmetic ops force the carry chain to 0
    always_comb begin
        y    = 4'h0;
        cout = 1'b0;
        c3   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                y    = sum[3:0];
                cout = sum[4];
                c3   = sum_lo[3];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHL: begin
                y    = {a[2:0], cin};
                cout = a[3];
            end
            OP_PASS: y = a;
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs W = 4*NIBBLES bit operations through one 4-bit slice, LSB nibble
// first, then publishes the result and full-width flags.
// Optional macro ALU_STICKY_OVF_EN adds a sticky overflow flag with clear.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, where
// out_y and flags stay stable until the out_valid && out_ready edge.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter  int NIBBLES = 2,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_carry,
    output logic         out_zero,
    output logic         out_sign,
    output logic         out_overflow,
`ifdef ALU_STICKY_OVF_EN
    input  logic         sticky_clr,
    output logic         sticky_ovf,
`endif
    output logic [1:0]   dbg_state
);

    // Counter reaching NIBBLES means every nibble has been through the slice
    localparam logic [2:0] LAST_CNT = 3'(NIBBLES);

    logic [1:0]   state;
    logic [2:0]   cnt;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] acc;
    logic         chain;
    logic         last_c3;

    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [3:0]   y_nib;
    logic         s_cout;
    logic         s_c3;
    logic         fin_carry;
    logic         fin_ovf;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign dbg_state = state;

    // Pick the operand nibbles addressed by the pass counter
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == 3'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    alu_nibble_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .op   (op_q),
        .cin  (chain),
        .y    (y_nib),
        .cout (s_cout),
        .c3   (s_c3)
    );

    // Final carry/overflow come from the last pass's chain state
    always_comb begin
        fin_carry = 1'b0;
        fin_ovf   = 1'b0;
        case (op_q)
            OP_ADD: begin
                fin_carry = chain;
                fin_ovf   = chain ^ last_c3;
            end
            OP_SUB: begin
                fin_carry = ~chain;
                fin_ovf   = chain ^ last_c3;
            end
            OP_SHL:  fin_carry = chain;
            default: fin_carry = 1'b0;
        endcase
    end

    // Sequencer FSM: accept, one nibble per cycle, flag cycle, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 3'd0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            acc          <= '0;
            chain        <= 1'b0;
            last_c3      <= 1'b0;
            out_y        <= '0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_sign     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        acc     <= '0;
                        cnt     <= 3'd0;
                        chain   <= (in_op == OP_SUB);
                        last_c3 <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST_CNT) begin
                        out_y        <= acc;
                        out_zero     <= (acc == '0);
                        out_sign     <= acc[W-1];
                        out_carry    <= fin_carry;
                        out_overflow <= fin_ovf;
                        state        <= ST_DONE;
                    end else begin
                        for (int i = 0; i < NIBBLES; i++) begin
                            if (cnt == 3'(i)) begin
                                acc[i*NIBBLE_W +: NIBBLE_W] <= y_nib;
                            end
                        end
                        chain   <= s_cout;
                        last_c3 <= s_c3;
                        cnt     <= cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: set on an overflowing result handshake, set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (out_valid && out_ready && out_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with NIBBLES=2 (8-bit operands).
// Defining ALU_STICKY_OVF_EN also exercises the sticky overflow flag.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int NIBBLES = 2;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_carry;
    logic         out_zero;
    logic         out_sign;
    logic         out_overflow;
    logic [1:0]   dbg_state;
`ifdef ALU_STICKY_OVF_EN
    logic         sticky_clr;
    logic         sticky_ovf;
`endif

    int checks;
    int failures;

    alu_op_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_sign     (out_sign),
        .out_overflow (out_overflow),
`ifdef ALU_STICKY_OVF_EN
        .sticky_clr   (sticky_clr),
        .sticky_ovf   (sticky_ovf),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         s;
        logic         v;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command and wait for out_valid; returns edges from acceptance
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands to confirm they were captured at acceptance
        in_a  = ~a;
        in_b  = ~b;
        in_op = ~op;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    // Complete the result handshake
    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_y;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
        sticky_clr = 1'b0;
`endif

        //           op       a      b      y      c     z     s     v
        vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR,  8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_OR,   8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_NOT,  8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{OP_PASS, 8'h80, 8'h12, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{OP_ADD,  8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_SUB,  8'h34, 8'h12, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_SHL,  8'h40, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y",     32'(out_y), 32'd0);
        check("rst_flags",     32'({out_carry, out_zero, out_sign, out_overflow}), 32'd0);

        // Table-driven operations
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_y", i), 32'(out_y), 32'(vecs[i].y));
            check($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].c));
            check($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].z));
            check($sformatf("v%0d_sign", i), 32'(out_sign), 32'(vecs[i].s));
            check($sformatf("v%0d_ovf", i), 32'(out_overflow), 32'(vecs[i].v));
            accept_result();
            check($sformatf("v%0d_idle_after", i), 32'(in_ready), 32'd1);
        end

        // Backpressure: result held 5 cycles, new command ignored
        issue(OP_ADD, 8'h7F, 8'h01, lat);
        held_y = out_y;
        check("bp_y_initial", 32'(held_y), 32'h80);
        in_valid = 1'b1;
        in_op    = OP_AND;
        in_a     = 8'h00;
        in_b     = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready), 32'd0);
            check("bp_y_stable",  32'(out_y), 32'(held_y));
            check("bp_flags",     32'({out_carry, out_zero, out_sign, out_overflow}), 32'b0011);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset mid-RUN abandons the operation
        in_op    = OP_ADD;
        in_a     = 8'h11;
        in_b     = 8'h22;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midrun_state", 32'(dbg_state), 32'(ST_RUN));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_y",     32'(out_y), 32'd0);
        check("midrun_rst_ready", 32'(in_ready), 32'd1);
        issue(OP_ADD, 8'h12, 8'h34, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_y",       32'(out_y), 32'h46);
        accept_result();

`ifdef ALU_STICKY_OVF_EN
        // Sticky overflow
        check("sticky_after_reset", 32'(sticky_ovf), 32'd0);
        issue(OP_ADD, 8'h7F, 8'h01, lat);
        accept_result();
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        issue(OP_ADD, 8'h01, 8'h01, lat);
        accept_result();
        check("sticky_hold", 32'(sticky_ovf), 32'd1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check("sticky_clear", 32'(sticky_ovf), 32'd0);
        sticky_clr = 1'b1;
        issue(OP_ADD, 8'h7F, 8'h01, lat);
        accept_result();
        sticky_clr = 1'b0;
        check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
